// File: rtl/pipe_scheduler.sv
// pipe_scheduler: sequences pipe generation for the scrolling playfield.
// Every consumed scroll tick emits one column to the framebuffer shifter:
// SPACING empty columns, then PIPE_W pipe columns with a GAP_H-row gap whose
// top row is rand_val + GAP_OFS, latched in a one-cycle LOAD state.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   enable       game running; low forces IDLE
//   tick         one-cycle scroll-step pulse
//   rand_val     current 3-bit pseudo-random value
//   col_ready    downstream accepts column
//   col_out      column pattern (bit 0 = top row, 1 = pipe pixel)
//   col_valid    col_out valid
//   rand_adv     one-cycle strobe advancing the random generator
//   pipe_spawned one-cycle pulse when a new gap is latched
//   overrun      sticky: a tick was lost
//
// Optional feature (macro PIPE_SCHED_SCORE_EN): adds score_pulse, a pulse on
// the handshake of each pipe's last column, and pipe_count, a saturating
// 8-bit count of those pulses that survives enable low.
module pipe_scheduler #(
    parameter int unsigned ROWS    = 16,
    parameter int unsigned GAP_H   = 4,
    parameter int unsigned GAP_OFS = 4,
    parameter int unsigned PIPE_W  = 2,
    parameter int unsigned SPACING = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            tick,
    input  logic [2:0]      rand_val,
    input  logic            col_ready,
    output logic [ROWS-1:0] col_out,
    output logic            col_valid,
    output logic            rand_adv,
    output logic            pipe_spawned,
`ifdef PIPE_SCHED_SCORE_EN
    output logic            score_pulse,
    output logic [7:0]      pipe_count,
`endif
    output logic            overrun
);

    localparam int unsigned GW   = $clog2(ROWS);
    localparam int unsigned CMAX = (SPACING > PIPE_W) ? SPACING : PIPE_W;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SPACING_C = CW'(SPACING);
    localparam logic [CW-1:0] PIPE_C    = CW'(PIPE_W);
    localparam logic [CW-1:0] ONE_C     = CW'(1);

    typedef enum logic [1:0] {IDLE, SPACE, LOAD, PIPE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            pend_q, pend_d;
    logic [ROWS-1:0] col_q, col_d;
    logic            valid_q, valid_d;
    logic            adv_q, adv_d;
    logic            spawn_q, spawn_d;
    logic            ovr_q, ovr_d;
    logic            consume;
    logic            handshake;

    // All ones except the GAP_H rows starting at top.
    function automatic logic [ROWS-1:0] pipe_pattern(input logic [GW-1:0] top);
        logic [ROWS-1:0] p;
        p = '1;
        for (int unsigned r = 0; r < ROWS; r++) begin
            p[r] = (r < 32'(top)) || (r >= 32'(top) + GAP_H);
        end
        return p;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        col_d     = col_q;
        valid_d   = valid_q;
        adv_d     = 1'b0;
        spawn_d   = 1'b0;
        ovr_d     = ovr_q;

        handshake = valid_q & col_ready;
        // A pending tick may only be turned into a column in SPACE/PIPE and
        // only when the output register is free or being emptied this edge.
        consume   = pend_q && (state_q == SPACE || state_q == PIPE) &&
                    (!valid_q || col_ready);
        pend_d    = consume ? tick : (pend_q | tick);
        if (tick && pend_q && !consume) begin
            ovr_d = 1'b1;
        end
        if (handshake) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = SPACE;
                cnt_d   = SPACING_C;
            end
            SPACE: begin
                if (consume) begin
                    col_d   = '0;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q - ONE_C;
                    if (cnt_q == ONE_C) begin
                        // Registered strobes line up with the LOAD cycle.
                        state_d = LOAD;
                        adv_d   = 1'b1;
                        spawn_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                gap_d   = GW'(rand_val) + GW'(GAP_OFS);
                state_d = PIPE;
                cnt_d   = PIPE_C;
            end
            PIPE: begin
                if (consume) begin
                    col_d   = pipe_pattern(gap_q);
                    valid_d = 1'b1;
                    cnt_d   = cnt_q - ONE_C;
                    if (cnt_q == ONE_C) begin
                        state_d = SPACE;
                        cnt_d   = SPACING_C;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!enable) begin
            state_d = IDLE;
            valid_d = 1'b0;
            pend_d  = 1'b0;
            adv_d   = 1'b0;
            spawn_d = 1'b0;
            ovr_d   = ovr_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            pend_q  <= 1'b0;
            col_q   <= '0;
            valid_q <= 1'b0;
            adv_q   <= 1'b0;
            spawn_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            adv_q   <= adv_d;
            spawn_q <= spawn_d;
            ovr_q   <= ovr_d;
        end
    end

    assign col_out      = col_q;
    assign col_valid    = valid_q;
    assign rand_adv     = adv_q;
    assign pipe_spawned = spawn_q;
    assign overrun      = ovr_q;

`ifdef PIPE_SCHED_SCORE_EN
    // last_q marks that the column currently held is a pipe's final column.
    logic       last_q, last_d;
    logic       score_q, score_d;
    logic [7:0] count_q, count_d;

    always_comb begin
        last_d  = last_q;
        if (consume) begin
            last_d = (state_q == PIPE) && (cnt_q == ONE_C);
        end
        score_d = handshake && last_q;
        count_d = count_q;
        if (score_d && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q  <= 1'b0;
            score_q <= 1'b0;
            count_q <= '0;
        end else begin
            last_q  <= last_d;
            score_q <= score_d;
            count_q <= count_d;
        end
    end

    assign score_pulse = score_q;
    assign pipe_count  = count_q;
`endif

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: a column-index reference model (column k of each
// SPACING+PIPE_W period is empty or a pipe; a one-cycle stall follows the last
// empty column) checked against the DUT on every cycle, plus directed phases
// with hand-computed column patterns.
module tb_pipe_scheduler;

    localparam int unsigned ROWS    = 16;
    localparam int unsigned GAP_H   = 4;
    localparam int unsigned GAP_OFS = 4;
    localparam int unsigned PIPE_W  = 2;
    localparam int unsigned SPACING = 6;
    localparam int unsigned PERIOD  = SPACING + PIPE_W;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic            tick = 1'b0;
    logic [2:0]      rand_val = 3'd0;
    logic            col_ready = 1'b1;
    logic [ROWS-1:0] col_out;
    logic            col_valid;
    logic            rand_adv;
    logic            pipe_spawned;
    logic            overrun;

    int total = 0;
    int bad   = 0;

    pipe_scheduler #(
        .ROWS(ROWS), .GAP_H(GAP_H), .GAP_OFS(GAP_OFS),
        .PIPE_W(PIPE_W), .SPACING(SPACING)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick),
        .rand_val(rand_val), .col_ready(col_ready), .col_out(col_out),
        .col_valid(col_valid), .rand_adv(rand_adv),
        .pipe_spawned(pipe_spawned), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ROWS-1:0] pipe_pat(input int unsigned gap);
        logic [ROWS-1:0] hole;
        hole = ROWS'(((32'd1 << GAP_H) - 1) << gap);
        return ~hole;
    endfunction

    // ---------------- reference model ----------------
    bit              m_run, m_pend, m_valid, m_stall, m_adv, m_ovr;
    logic [ROWS-1:0] m_col;
    int unsigned     m_k, m_gap;

    initial begin
        bit cons, nv;
        int unsigned pos;
        logic [ROWS-1:0] ncol;
        m_run = 0; m_pend = 0; m_valid = 0; m_stall = 0; m_adv = 0;
        m_ovr = 0; m_col = '0; m_k = 0; m_gap = 0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_run = 0; m_pend = 0; m_valid = 0; m_stall = 0; m_adv = 0;
                m_ovr = 0; m_col = '0; m_k = 0; m_gap = 0;
            end else if (!enable) begin
                m_run = 0; m_pend = 0; m_valid = 0; m_stall = 0; m_adv = 0;
            end else begin
                cons = m_run && !m_stall && m_pend && (!m_valid || col_ready);
                if (tick && m_pend && !cons) m_ovr = 1;
                nv   = m_valid;
                ncol = m_col;
                if (m_stall) begin
                    m_gap   = int'(rand_val) + GAP_OFS;
                    m_stall = 0;
                end
                m_adv = 0;
                if (cons) begin
                    pos  = m_k % PERIOD;
                    ncol = (pos < SPACING) ? '0 : pipe_pat(m_gap);
                    nv   = 1;
                    if (pos == SPACING - 1) begin
                        m_stall = 1;
                        m_adv   = 1;
                    end
                    m_k++;
                end else if (m_valid && col_ready) begin
                    nv = 0;
                end
                m_pend = cons ? tick : (m_pend | tick);
                if (!m_run) m_k = 0;
                m_run   = 1;
                m_valid = nv;
                m_col   = ncol;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("col_valid", 32'(col_valid), 32'(m_valid));
                if (m_valid) chk("col_out", 32'(col_out), 32'(m_col));
                chk("rand_adv", 32'(rand_adv), 32'(m_adv));
                chk("pipe_spawned", 32'(pipe_spawned), 32'(m_adv));
                chk("overrun", 32'(overrun), 32'(m_ovr));
            end
        end
    end

    // ---------------- accepted-column capture ----------------
    logic [ROWS-1:0] acc[$];
    int adv_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset && col_valid && col_ready) acc.push_back(col_out);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset && rand_adv) adv_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_tick(input int gap);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic run_pipe(input string nm, input logic [2:0] rv,
                            input logic [ROWS-1:0] exp_pipe);
        rand_val = rv;
        acc.delete();
        adv_cnt = 0;
        for (int i = 0; i < 8; i++) pulse_tick(4);
        repeat (3) @(negedge clk);
        chk({nm, "_ncols"}, 32'(acc.size()), 32'd8);
        for (int i = 0; i < 8 && i < acc.size(); i++)
            chk(nm, 32'(acc[i]), (i < 6) ? 32'd0 : 32'(exp_pipe));
        chk({nm, "_adv_pulses"}, 32'(adv_cnt), 32'd1);
    endtask

    initial begin
        logic [ROWS-1:0] held;
        bit found;

        // Reset held with tick toggling.
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick = ~tick;
            @(negedge clk);
        end
        tick = 1'b0;
        chk("rst_col_valid", 32'(col_valid), 32'd0);
        chk("rst_rand_adv", 32'(rand_adv), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_col_out", 32'(col_out), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Spacing then pipe, plus gap boundaries.
        run_pipe("pipe_rv3", 3'd3, 16'hF87F);
        run_pipe("pipe_rv0", 3'd0, 16'hFF0F);
        run_pipe("pipe_rv7", 3'd7, 16'h87FF);

        // Backpressure.
        col_ready = 1'b0;
        pulse_tick(1);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (col_valid) found = 1;
            else @(negedge clk);
        end
        chk("bp_valid_seen", 32'(found), 32'd1);
        held = col_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(col_valid), 32'd1);
            chk("bp_hold_col", 32'(col_out), 32'(held));
        end
        pulse_tick(1);
        chk("bp_pend_no_ovr", 32'(overrun), 32'd0);
        pulse_tick(1);
        chk("bp_ovr_set", 32'(overrun), 32'd1);
        col_ready = 1'b1;
        @(negedge clk);
        chk("bp_b2b_valid", 32'(col_valid), 32'd1);
        @(negedge clk);
        chk("bp_drain_valid", 32'(col_valid), 32'd0);

        // Tick during LOAD.
        rand_val = 3'd5;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (rand_adv) found = 1;
            else tick = (i % 3 == 0);
        end
        chk("load_seen", 32'(found), 32'd1);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        chk("load_tick_valid", 32'(col_valid), 32'd1);
        chk("load_tick_col", 32'(col_out), 32'hE1FF);

        // Enable dropped after the first of two pipe columns.
        enable = 1'b0;
        @(negedge clk);
        chk("dis_valid", 32'(col_valid), 32'd0);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        run_pipe("reen_rv3", 3'd3, 16'hF87F);
        chk("reen_ovr_kept", 32'(overrun), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_val  = 3'($urandom_range(0, 7));
            tick      = ($urandom_range(0, 2) == 0);
            col_ready = ($urandom_range(0, 2) != 0);
            enable    = ($urandom_range(0, 99) != 0);
            @(negedge clk);
        end
        tick = 1'b0;

        // Reset mid-run clears the sticky overrun.
        reset = 1'b0;
        @(negedge clk);
        chk("rst2_overrun", 32'(overrun), 32'd0);
        chk("rst2_valid", 32'(col_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_scheduler.md
Name: pipe_scheduler

Overview:
Sequences pipe generation for the scrolling playfield.
- On every scroll tick, emits one display column: either empty spacing or a pipe column with a gap.
- Gap position comes from the 3-bit pseudo-random generator. The block strobes that generator to advance once per pipe.
- Columns go to the framebuffer shifter over a valid/ready handshake.

Parameters:
ROWS, 16, playfield height in rows; width of col_out
GAP_H, 4, gap height in rows
GAP_OFS, 4, row offset added to rand_val; constraint 7+GAP_OFS+GAP_H <= ROWS
PIPE_W, 2, pipe width in columns
SPACING, 6, empty columns before each pipe

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  game running; low forces IDLE
tick  in  1  one-cycle scroll-step pulse
rand_val  in  3  current pseudo-random value
col_ready  in  1  downstream accepts column
col_out  out  ROWS  column pattern; bit 0 = top row; 1 = pipe pixel
col_valid  out  1  col_out valid
rand_adv  out  1  one-cycle strobe to advance the random generator
pipe_spawned  out  1  one-cycle pulse when a new pipe's gap is latched
overrun  out  1  sticky: a tick was lost

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, col_out=0, col_valid=0, rand_adv=0, pipe_spawned=0, overrun=0, tick_pend=0, counters=0, gap_top=0.
- FSM states: IDLE, SPACE, LOAD, PIPE.
- IDLE -> SPACE when enable=1; column counter loads SPACING.
- SPACE:
  - each consumed tick emits col_out=0 and decrements the counter;
  - after the SPACING-th empty column is emitted -> LOAD.
- LOAD (exactly 1 cycle):
  - gap_top <= rand_val + GAP_OFS;
  - rand_adv=1 and pipe_spawned=1 for this cycle;
  - -> PIPE; counter loads PIPE_W.
- PIPE:
  - each consumed tick emits the pipe pattern: all ones except rows gap_top..gap_top+GAP_H-1, which are 0;
  - after the PIPE_W-th column -> SPACE; counter reloads SPACING.
- Tick pending latch (single entry):
  - tick=1 sets tick_pend;
  - tick_pend is consumed in SPACE/PIPE only when col_valid=0 or (col_valid & col_ready) this cycle.
  - Consumption loads col_out and sets col_valid=1 on the next edge. Latency is 1 clock from consumable tick to col_valid.
  - A tick arriving in LOAD or IDLE->SPACE stays pending and is consumed the next eligible cycle.
  - tick=1 while tick_pend=1 and not consumed this cycle: tick dropped, overrun<=1.
  - Simultaneous consume and new tick: tick_pend stays 1, no overrun.
- Handshake:
  - col_valid holds and col_out is stable until col_valid & col_ready at an edge.
  - col_valid falls the next cycle unless a pending tick is consumed in the same cycle (back-to-back allowed).
  - col_ready is ignored while col_valid=0.
- enable low at any edge:
  - next state IDLE; col_valid<=0; tick_pend<=0; rand_adv, pipe_spawned <=0;
  - overrun is kept;
  - re-enable restarts at SPACE with full SPACING count.
- overrun clears only on reset.
- Arithmetic: gap_top width = clog2(ROWS). Parameter constraint guarantees no wrap. Counters are sized for max(SPACING, PIPE_W).

Optional Feature:
Macro PIPE_SCHED_SCORE_EN.
- Defined: adds outputs score_pulse (1) and pipe_count (8).
  - score_pulse is a one-cycle pulse on the handshake of the last column of each pipe.
  - pipe_count increments on each score_pulse and saturates at 255.
  - Both reset to 0; enable low does not clear pipe_count.
- Not defined: ports absent; no score logic.

Test Plan:
- Reset held low with tick toggling -> col_valid=0, rand_adv=0, overrun=0. Release reset with enable=1 -> state SPACE.
- Defaults, col_ready=1, 6 ticks -> six col_out=16'h0000 columns; 1-cycle LOAD pulse on rand_adv/pipe_spawned; rand_val=3 latched; next 2 ticks -> col_out=16'hF87F each.
- Gap boundaries: rand_val=0 -> pipe columns 16'hFF0F; rand_val=7 -> 16'h87FF.
- Backpressure: col_ready=0 for 5 cycles after col_valid -> col_out stable, col_valid held.
  - one further tick -> pending, no overrun; second further tick -> overrun=1 sticky.
  - col_ready=1 -> pending column emitted back-to-back.
- Tick in LOAD cycle -> not lost; first pipe column valid 1 cycle after LOAD exits.
- enable dropped mid-PIPE (after 1 of 2 columns) -> col_valid=0 next cycle, IDLE. Re-enable -> 6 empty columns before next pipe; overrun unchanged.
